// File: rtl/lcd_cmd_sequencer.sv
// Command FIFO plus an issue scheduler for LCD_CTRL. Commands are sent one at a
// time over the cmd_valid/busy handshake. After a WRITE (frame-finish) command,
// the scheduler holds further commands until lcd_done arrives, then pulses
// frame_done.
module lcd_cmd_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned WRITE_CODE = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CMD_W-1:0]         host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [CMD_W-1:0]         lcd_cmd,
  output logic                     lcd_cmd_valid,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic                     frame_done,
  output logic                     seq_idle
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GUARD     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CMD_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CMD_W-1:0]   lcd_cmd_q, lcd_cmd_d;
  logic               lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               push;
  logic               pop;
  logic [CMD_W-1:0]   head;

  assign head = mem_q[rd_ptr_q];

  // FIFO accepts whenever not full; derived only from the stored level.
  assign host_ready    = (level_q != LVL_W'(DEPTH));
  assign push          = host_valid & host_ready;
  assign fifo_level    = level_q;
  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_cmd_valid = lcd_cmd_valid_q;
  assign issued_cnt    = issued_cnt_q;
  assign frame_done    = frame_done_q;
  assign seq_idle      = (state_q == IDLE) && (level_q == LVL_W'(0));

  // Scheduler: next state, issue decision and registered output values.
  always_comb begin
    state_d         = state_q;
    lcd_cmd_d       = lcd_cmd_q;
    lcd_cmd_valid_d = 1'b0;
    issued_cnt_d    = issued_cnt_q;
    frame_done_d    = 1'b0;
    pop             = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((level_q != LVL_W'(0)) && !lcd_busy) begin
          pop             = 1'b1;
          lcd_cmd_d       = head;
          lcd_cmd_valid_d = 1'b1;
          issued_cnt_d    = issued_cnt_q + CNT_W'(1);
          state_d         = (head == CMD_W'(WRITE_CODE)) ? WAIT_DONE : GUARD;
        end
      end
      // busy may still read low while LCD_CTRL samples cmd_valid, so skip a cycle
      GUARD: begin
        state_d = IDLE;
      end
      WAIT_DONE: begin
        if (lcd_done) begin
          state_d      = FINISH;
          frame_done_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer and level update; simultaneous push and pop keep the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_cmd;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      lcd_cmd_q       <= '0;
      lcd_cmd_valid_q <= 1'b0;
      issued_cnt_q    <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      issued_cnt_q    <= issued_cnt_d;
      frame_done_q    <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: cycle-by-cycle vector table plus
// hand-written sequences for full-FIFO back-pressure and async reset.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] fifo_level;
  logic [7:0] issued_cnt;
  logic       frame_done;
  logic       seq_idle;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       hv;
    logic [3:0] hc;
    logic       busy;
    logic       done;
    logic       e_valid;
    logic [3:0] e_cmd;
    logic [3:0] e_lvl;
    logic       e_rdy;
    logic       e_fd;
    logic       e_idle;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 34;
  vec_t vt [NV];

  lcd_cmd_sequencer #(
    .DEPTH(8), .CMD_W(4), .WRITE_CODE(0), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .host_cmd(host_cmd), .host_valid(host_valid), .host_ready(host_ready),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .fifo_level(fifo_level), .issued_cnt(issued_cnt),
    .frame_done(frame_done), .seq_idle(seq_idle)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic hv, input logic [3:0] hc, input logic busy,
                              input logic done, input logic ev, input logic [3:0] ec,
                              input logic [3:0] el, input logic er, input logic efd,
                              input logic ei, input logic [7:0] ecnt);
    vec_t v;
    v.hv = hv; v.hc = hc; v.busy = busy; v.done = done;
    v.e_valid = ev; v.e_cmd = ec; v.e_lvl = el; v.e_rdy = er;
    v.e_fd = efd; v.e_idle = ei; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h expected %0h at t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic chk_all(input int idx, input logic ev, input logic [3:0] ec,
                         input logic [3:0] el, input logic er, input logic efd,
                         input logic ei, input logic [7:0] ecnt);
    chk("lcd_cmd_valid", idx, 32'(lcd_cmd_valid), 32'(ev));
    chk("lcd_cmd",       idx, 32'(lcd_cmd),       32'(ec));
    chk("fifo_level",    idx, 32'(fifo_level),    32'(el));
    chk("host_ready",    idx, 32'(host_ready),    32'(er));
    chk("frame_done",    idx, 32'(frame_done),    32'(efd));
    chk("seq_idle",      idx, 32'(seq_idle),      32'(ei));
    chk("issued_cnt",    idx, 32'(issued_cnt),    32'(ecnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] got [$];
    logic       prev_valid;

    //         hv hc bsy dn | vld cmd lvl rdy fd idle cnt
    vt[0]  = mk(1, 1, 1, 0,   0,  0,  1,  1,  0, 0,  0);
    vt[1]  = mk(1, 2, 1, 0,   0,  0,  2,  1,  0, 0,  0);
    vt[2]  = mk(1, 3, 1, 0,   0,  0,  3,  1,  0, 0,  0);
    vt[3]  = mk(0, 0, 1, 0,   0,  0,  3,  1,  0, 0,  0);
    vt[4]  = mk(0, 0, 0, 0,   1,  1,  2,  1,  0, 0,  1);
    vt[5]  = mk(0, 0, 0, 0,   0,  1,  2,  1,  0, 0,  1);
    vt[6]  = mk(0, 0, 0, 0,   1,  2,  1,  1,  0, 0,  2);
    vt[7]  = mk(0, 0, 0, 0,   0,  2,  1,  1,  0, 0,  2);
    vt[8]  = mk(0, 0, 0, 0,   1,  3,  0,  1,  0, 0,  3);
    vt[9]  = mk(0, 0, 0, 0,   0,  3,  0,  1,  0, 1,  3);
    vt[10] = mk(1, 1, 0, 0,   0,  3,  1,  1,  0, 0,  3);
    vt[11] = mk(1, 2, 0, 0,   1,  1,  1,  1,  0, 0,  4);
    vt[12] = mk(1, 3, 0, 0,   0,  1,  2,  1,  0, 0,  4);
    vt[13] = mk(1, 4, 0, 0,   1,  2,  2,  1,  0, 0,  5);
    vt[14] = mk(0, 0, 0, 0,   0,  2,  2,  1,  0, 0,  5);
    vt[15] = mk(0, 0, 0, 0,   1,  3,  1,  1,  0, 0,  6);
    vt[16] = mk(0, 0, 0, 0,   0,  3,  1,  1,  0, 0,  6);
    vt[17] = mk(0, 0, 0, 0,   1,  4,  0,  1,  0, 0,  7);
    vt[18] = mk(0, 0, 0, 0,   0,  4,  0,  1,  0, 1,  7);
    vt[19] = mk(1, 1, 0, 0,   0,  4,  1,  1,  0, 0,  7);
    vt[20] = mk(1, 0, 0, 0,   1,  1,  1,  1,  0, 0,  8);
    vt[21] = mk(1, 2, 0, 0,   0,  1,  2,  1,  0, 0,  8);
    vt[22] = mk(0, 0, 0, 0,   1,  0,  1,  1,  0, 0,  9);
    vt[23] = mk(0, 0, 0, 0,   0,  0,  1,  1,  0, 0,  9);
    vt[24] = mk(0, 0, 0, 0,   0,  0,  1,  1,  0, 0,  9);
    vt[25] = mk(1, 5, 0, 0,   0,  0,  2,  1,  0, 0,  9);
    vt[26] = mk(0, 0, 0, 1,   0,  0,  2,  1,  1, 0,  9);
    vt[27] = mk(0, 0, 0, 0,   0,  0,  2,  1,  0, 0,  9);
    vt[28] = mk(0, 0, 0, 0,   1,  2,  1,  1,  0, 0, 10);
    vt[29] = mk(0, 0, 0, 0,   0,  2,  1,  1,  0, 0, 10);
    vt[30] = mk(0, 0, 0, 0,   1,  5,  0,  1,  0, 0, 11);
    vt[31] = mk(0, 0, 0, 0,   0,  5,  0,  1,  0, 1, 11);
    vt[32] = mk(0, 0, 0, 1,   0,  5,  0,  1,  0, 1, 11);
    vt[33] = mk(0, 0, 0, 0,   0,  5,  0,  1,  0, 1, 11);

    reset      = 1'b0;
    host_cmd   = 4'd0;
    host_valid = 1'b0;
    lcd_busy   = 1'b0;
    lcd_done   = 1'b0;
    step();
    step();
    chk_all(100, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    reset = 1'b1;

    // Busy stall, issue spacing, frame end, and stray done: one vector per cycle
    for (int i = 0; i < NV; i++) begin
      host_valid = vt[i].hv;
      host_cmd   = vt[i].hc;
      lcd_busy   = vt[i].busy;
      lcd_done   = vt[i].done;
      step();
      chk_all(i, vt[i].e_valid, vt[i].e_cmd, vt[i].e_lvl, vt[i].e_rdy,
              vt[i].e_fd, vt[i].e_idle, vt[i].e_cnt);
    end
    host_valid = 1'b0;
    lcd_done   = 1'b0;

    // Full FIFO: eight pushes while busy, ninth is held until space frees
    lcd_busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      host_valid = 1'b1;
      host_cmd   = 4'(k);
      step();
      chk("full_level", k, 32'(fifo_level), 32'(k));
    end
    host_cmd = 4'd9;
    step();
    chk("full_ready", 200, 32'(host_ready), 32'd0);
    chk("full_level", 200, 32'(fifo_level), 32'd8);
    chk("full_valid", 200, 32'(lcd_cmd_valid), 32'd0);
    lcd_busy = 1'b0;
    step();
    chk("rel_valid", 201, 32'(lcd_cmd_valid), 32'd1);
    chk("rel_cmd",   201, 32'(lcd_cmd),       32'd1);
    chk("rel_level", 201, 32'(fifo_level),    32'd7);
    chk("rel_ready", 201, 32'(host_ready),    32'd1);
    step();
    chk("ninth_level", 202, 32'(fifo_level),    32'd8);
    chk("ninth_valid", 202, 32'(lcd_cmd_valid), 32'd0);
    host_valid = 1'b0;
    prev_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (lcd_cmd_valid) begin
        got.push_back(lcd_cmd);
        if (prev_valid) begin
          chk("back_to_back", 300 + c, 32'(prev_valid), 32'd0);
        end
      end
      prev_valid = lcd_cmd_valid;
    end
    chk("drain_count", 203, 32'(got.size()), 32'd8);
    for (int k = 0; k < got.size() && k < 8; k++) begin
      chk("drain_order", k, 32'(got[k]), 32'(k + 2));
    end
    chk("drain_cnt",   204, 32'(issued_cnt), 32'd20);
    chk("drain_level", 204, 32'(fifo_level), 32'd0);
    chk("drain_idle",  204, 32'(seq_idle),   32'd1);

    // Async reset while waiting for done with three commands queued
    host_valid = 1'b1; host_cmd = 4'd0; step();
    host_cmd = 4'd3; step();
    chk("wr_valid", 400, 32'(lcd_cmd_valid), 32'd1);
    host_cmd = 4'd4; step();
    host_cmd = 4'd5; step();
    host_valid = 1'b0; step();
    chk("wd_level", 401, 32'(fifo_level), 32'd3);
    chk("wd_cnt",   401, 32'(issued_cnt), 32'd21);
    chk("wd_valid", 401, 32'(lcd_cmd_valid), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk_all(402, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    #2;
    reset = 1'b1;
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_all(410 + c, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
